// File: rtl/move_cmd_if.sv
// Pushbutton/game-state inputs and one-hot move pulses of move_cmd_gen.
interface move_cmd_if;
    logic [3:0] key;         // active-low: [3]=left [2]=down [1]=up [0]=right
    logic       lost;
    logic       l, r, u, d;
    logic [7:0] move_count;

    modport master (output key, lost, input l, r, u, d, move_count);
    modport slave  (input key, lost, output l, r, u, d, move_count);
endinterface

// File: rtl/move_cmd_gen.sv
// Turns raw active-low pushbuttons into prioritised one-cycle move pulses with cooldown.
// Define MOVE_REPEAT_EN to add the HOLD state (auto-repeat while a key stays held).
module move_cmd_gen #(
    parameter int unsigned COOLDOWN   = 4,
    parameter int unsigned REPEAT_DLY = 16,
    parameter int unsigned REPEAT_PER = 8
) (
    input  logic      clk,
    input  logic      rst,
    move_cmd_if.slave bus
);
    // Direction codes double as the KEY bit index of each button.
    typedef enum logic [1:0] {DIR_R = 2'd0, DIR_U = 2'd1, DIR_D = 2'd2, DIR_L = 2'd3} dir_e;
`ifdef MOVE_REPEAT_EN
    typedef enum logic [1:0] {ARM, IDLE, COOL, HOLD} state_e;
    localparam int unsigned   REP_MAX   = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned   RW        = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PER);
`else
    typedef enum logic [1:0] {ARM, IDLE, COOL} state_e;
`endif
    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN);

    logic [3:0] sync1_q, sync2_q, hist_q;
    logic [1:0] settle_q;
    state_e     state_q;
    logic [7:0] cool_q;
    logic [3:0] pulse_q;
    logic [7:0] count_q, count_d;
    logic [3:0] press;
    dir_e       pick;
`ifdef MOVE_REPEAT_EN
    dir_e          fired_q;
    logic [RW-1:0] rep_q;
    logic          first_q;
`endif

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        press = hist_q & ~sync2_q;
        pick  = DIR_R;
        if      (press[DIR_U]) pick = DIR_U;
        else if (press[DIR_D]) pick = DIR_D;
        else if (press[DIR_L]) pick = DIR_L;
        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            hist_q   <= '1;
            settle_q <= '0;
            state_q  <= ARM;
            cool_q   <= '0;
            pulse_q  <= '0;
            count_q  <= '0;
`ifdef MOVE_REPEAT_EN
            fired_q  <= DIR_R;
            rep_q    <= '0;
            first_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= bus.key;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            // ARM may only judge the keys once the synchronizer holds real samples.
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
            pulse_q <= '0;
            if (bus.lost) begin
                state_q <= ARM;
                cool_q  <= '0;
`ifdef MOVE_REPEAT_EN
                rep_q   <= '0;
                first_q <= 1'b0;
`endif
            end else begin
                unique case (state_q)
                    ARM: begin
                        if (settle_q == 2'd2 && (&sync2_q)) state_q <= IDLE;
                    end
                    IDLE: begin
                        if (|press) begin
                            pulse_q <= 4'b0001 << pick;
                            count_q <= count_d;
                            cool_q  <= COOL_LOAD;
                            state_q <= COOL;
`ifdef MOVE_REPEAT_EN
                            fired_q <= pick;
                            rep_q   <= RW'(1);
                            first_q <= 1'b1;
`endif
                        end
                    end
                    COOL: begin
                        cool_q <= cool_q - 8'd1;
`ifdef MOVE_REPEAT_EN
                        rep_q  <= rep_q + RW'(1);
                        if (cool_q == 8'd1) state_q <= sync2_q[fired_q] ? IDLE : HOLD;
`else
                        if (cool_q == 8'd1) state_q <= IDLE;
`endif
                    end
`ifdef MOVE_REPEAT_EN
                    HOLD: begin
                        // rep_q counts cycles since the last pulse of the held key.
                        if (sync2_q[fired_q]) begin
                            state_q <= IDLE;
                        end else if (rep_q == (first_q ? REP_FIRST : REP_NEXT)) begin
                            pulse_q <= 4'b0001 << fired_q;
                            count_q <= count_d;
                            cool_q  <= COOL_LOAD;
                            state_q <= COOL;
                            rep_q   <= RW'(1);
                            first_q <= 1'b0;
                        end else begin
                            rep_q <= rep_q + RW'(1);
                        end
                    end
`endif
                    default: state_q <= ARM;
                endcase
            end
        end
    end

    assign bus.r          = pulse_q[DIR_R];
    assign bus.u          = pulse_q[DIR_U];
    assign bus.d          = pulse_q[DIR_D];
    assign bus.l          = pulse_q[DIR_L];
    assign bus.move_count = count_q;
endmodule

// File: tb/tb_move_cmd_gen.sv
// Scoreboard bench for move_cmd_gen: event-level reference model plus randomised key traffic.
// Build with MOVE_REPEAT_EN defined to also exercise auto-repeat.
module tb_move_cmd_gen;
    localparam int COOL = 4;
    localparam int DLY  = 16;
    localparam int PER  = 8;
`ifdef MOVE_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] pulses;   // {L, D, U, R}, same order as KEY
        logic [7:0] cnt;
    } exp_t;
    typedef enum {M_ARM, M_IDLE, M_COOL, M_HOLD} mode_e;

    logic clk = 1'b0;
    logic rst;
    move_cmd_if bus ();

    move_cmd_gen #(
        .COOLDOWN  (COOL),
        .REPEAT_DLY(DLY),
        .REPEAT_PER(PER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    // Reference model: key samples indexed by edge number, deadlines as edge numbers.
    mode_e      m_mode;
    int         m_n, m_cool_exit, m_last, m_fired, m_count;
    bit         m_first;
    logic [3:0] m_samples[$];
    logic [3:0] m_last_pulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    function automatic void model_reset();
        m_samples.delete();
        repeat (3) m_samples.push_back(4'hF);   // edges -2..0 look released
        m_n          = 0;
        m_mode       = M_ARM;
        m_count      = 0;
        m_cool_exit  = 0;
        m_last       = 0;
        m_fired      = 0;
        m_first      = 1'b0;
        m_last_pulse = 4'h0;
    endfunction

    function automatic void model_edge(input logic [3:0] key, input logic lost);
        logic [3:0] cur, prv, pressed;
        int         fire_dir  = -1;
        bit         from_idle = 1'b0;
        int         prio[4]   = '{1, 2, 3, 0};   // U > D > L > R
        exp_t       e;
        m_n++;
        m_samples.push_back(key);
        cur     = m_samples[m_n];       // key seen two edges ago
        prv     = m_samples[m_n - 1];
        pressed = ~cur & prv;
        if (lost) begin
            m_mode = M_ARM;
        end else begin
            case (m_mode)
                M_ARM:  if (m_n >= 3 && cur == 4'hF) m_mode = M_IDLE;
                M_IDLE: begin
                    for (int i = 0; i < 4; i++)
                        if (fire_dir < 0 && pressed[prio[i]]) begin
                            fire_dir  = prio[i];
                            from_idle = 1'b1;
                        end
                end
                M_COOL: if (m_n == m_cool_exit) m_mode = (REP && !cur[m_fired]) ? M_HOLD : M_IDLE;
                M_HOLD: begin
                    if (cur[m_fired]) m_mode = M_IDLE;
                    else if (m_n - m_last == (m_first ? DLY : PER)) fire_dir = m_fired;
                end
                default: m_mode = M_ARM;
            endcase
        end
        e.pulses = 4'h0;
        if (fire_dir >= 0) begin
            e.pulses[fire_dir] = 1'b1;
            if (m_count < 255) m_count++;
            m_mode      = M_COOL;
            m_cool_exit = m_n + COOL;
            m_last      = m_n;
            m_fired     = fire_dir;
            m_first     = from_idle;
        end
        e.cnt        = 8'(m_count);
        m_last_pulse = e.pulses;
        exp_q.push_back(e);
    endfunction

    // Every stimulus task is entered and left at a falling edge.
    task automatic cycle(input logic [3:0] key, input logic lost = 1'b0);
        bus.key  = key;
        bus.lost = lost;
        model_edge(key, lost);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [3:0] key = 4'hF);
        repeat (n) cycle(key);
    endtask

    task automatic press(input logic [3:0] key, input int low, input int high);
        repeat (low) cycle(key);
        repeat (high) cycle(4'hF);
    endtask

    task automatic do_reset(input logic [3:0] key);
        rst      = 1'b1;
        bus.key  = key;
        bus.lost = 1'b0;
        #1;
        check("async reset pulses", {bus.l, bus.d, bus.u, bus.r}, 32'h0);
        check("async reset count", bus.move_count, 32'h0);
        model_reset();
        repeat (3) begin
            exp_q.push_back('0);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic run_until_pulse(input logic [3:0] key);
        int guard = 0;
        do begin
            cycle(key);
            guard++;
        end while (m_last_pulse == 4'h0 && guard < 20);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pulses {L,D,U,R}", {bus.l, bus.d, bus.u, bus.r}, e.pulses);
                check("move_count", bus.move_count, e.cnt);
            end else if ({bus.l, bus.d, bus.u, bus.r} != 4'h0) begin
                check("unexpected pulse", {bus.l, bus.d, bus.u, bus.r}, 32'h0);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] rkey;
        logic       rlost;
        int         hold;
        rst      = 1'b1;
        bus.key  = 4'hF;
        bus.lost = 1'b0;
        @(negedge clk);
        do_reset(4'hF);
        idle(5);

        // Single press, then simultaneous presses resolved by priority.
        press(4'b1101, 10, 8);
        press(4'b0101, 10, 8);
        press(4'b1100, 6, 8);
        press(4'b0011, 6, 8);
        press(4'b0110, 6, 8);

        // Re-press at growing distances across the end of cooldown.
        for (int g = 1; g <= 10; g++) begin
            press(4'b1110, 3, g);
            press(4'b1110, 3, 10);
        end

        // Key held through reset: nothing until release and re-press.
        do_reset(4'b1011);
        idle(10, 4'b1011);
        idle(6);
        press(4'b1011, 5, 8);

        // lost blocks everything; a key held as lost falls must not fire.
        for (int i = 0; i < 20; i++) begin
            cycle(i[0] ? 4'hF : 4'b0101, 1'b1);
            cycle(i[0] ? 4'hF : 4'b0101, 1'b1);
        end
        repeat (3) cycle(4'b0111, 1'b1);
        idle(10, 4'b0111);
        idle(6);
        press(4'b0111, 4, 8);

        // Reset mid-pulse (key still held) and mid-cooldown.
        run_until_pulse(4'b1101);
        do_reset(4'b1101);
        idle(5, 4'b1101);
        idle(6);
        run_until_pulse(4'b1110);
        idle(2);
        do_reset(4'hF);
        idle(5);
        press(4'b1110, 4, 8);

        // Random traffic with occasional lost and reset.
        hold  = 0;
        rkey  = 4'hF;
        rlost = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                rkey  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                rlost = ($urandom_range(0, 15) == 0);
                hold  = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 299) == 0) do_reset(rkey);
            cycle(rkey, rlost);
        end
        idle(8);

`ifdef MOVE_REPEAT_EN
        // Held key auto-repeats; long hold drives the count into saturation.
        do_reset(4'hF);
        idle(5);
        idle(60, 4'b1110);
        idle(10);
        idle(2200, 4'b1110);
        idle(10);
        check("saturated count (repeat)", bus.move_count, 32'd255);
        do_reset(4'hF);
        idle(5);
`endif

        for (int i = 0; i < 260; i++) press(4'b1110, 3, 6);
        check("saturated count", bus.move_count, 32'd255);
        press(4'b1101, 3, 6);

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/move_cmd_gen.md
MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 Parameter COOLDOWN, default 4: number of lockout cycles after each emitted move pulse (range 1..255).
REQ-002 Parameter REPEAT_DLY, default 16: hold cycles before the first auto-repeat pulse (used only with MOVE_REPEAT_EN).
REQ-003 Parameter REPEAT_PER, default 8: cycles between later auto-repeat pulses (used only with MOVE_REPEAT_EN).
REQ-004 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 KEY  input  4  raw pushbuttons, active-low, asynchronous; KEY[3]=left, KEY[2]=down, KEY[1]=up, KEY[0]=right.
REQ-007 lost  input  1  game-over flag; high suppresses all moves.
REQ-008 L, R, U, D  output  1 each  one-cycle move pulses to the frog array.
REQ-009 move_count  output  8  saturating count of emitted move pulses.

Function
REQ-010 Each KEY bit SHALL pass through a 2-flop synchronizer; a press is a synced 1->0 transition, detected against a third history flop.
REQ-011 In IDLE, a move pulse SHALL be high for exactly one cycle, in the cycle after the 3rd rising edge at which KEY is sampled low.
REQ-012 At most one of L/R/U/D SHALL be high in any cycle; for simultaneous presses, priority is U > D > L > R; the losing presses are discarded.
REQ-013 States SHALL be ARM, IDLE, COOL and HOLD (HOLD only with MOVE_REPEAT_EN).
REQ-014 ARM -> IDLE when all four synced keys read released (1); no pulses in ARM.
REQ-015 IDLE -> COOL on the cycle a pulse is emitted; the cooldown counter loads COOLDOWN.
REQ-016 COOL: the counter decrements each cycle; presses are discarded; at count 0, -> HOLD if MOVE_REPEAT_EN and the fired key is still held, else -> IDLE.
REQ-017 move_count SHALL increment by 1 per emitted pulse and saturate at 255 (no wrap).
REQ-018 lost=1 in any state SHALL force ARM, hold all pulses low, and clear the cooldown and repeat counters; move_count holds its value.
REQ-019 After lost falls, a key still held SHALL NOT fire; the ARM release rule applies.
REQ-020 A press arriving on the same cycle that COOL ends SHALL be discarded; a new edge is required.

Reset
REQ-021 Reset SHALL asynchronously force: state=ARM, L=R=U=D=0, move_count=0, counters=0, synchronizer and history flops=1.
REQ-022 A key held across reset deassertion SHALL NOT produce a pulse until it is released and pressed again.
REQ-023 Reset asserted mid-pulse or mid-COOL SHALL drop the pulse in the same cycle and discard the remaining cooldown.

Configuration
REQ-024 Macro MOVE_REPEAT_EN defined: HOLD state present; a key held continuously for REPEAT_DLY cycles after its pulse fires again, then every REPEAT_PER cycles, each repeat followed by COOL and counted in move_count. Release returns to IDLE. lost and reset exit HOLD immediately.
REQ-025 Macro MOVE_REPEAT_EN undefined: no HOLD state; a held key produces exactly one pulse; REPEAT_DLY and REPEAT_PER are ignored.

Verification
REQ-026 Reset, all keys released, KEY[1] low for 10 cycles -> U high for exactly 1 cycle, 3 edges after the first low sample; move_count=1.
REQ-027 KEY[1] and KEY[3] fall on the same cycle -> U pulse only; L stays 0; move_count=1.
REQ-028 COOLDOWN=4: KEY[0] pulse, then released and pressed again 2 cycles later -> no second R; press at 8+ cycles -> second R.
REQ-029 KEY[2] held through reset deassertion -> no D; release, then press -> exactly one D.
REQ-030 lost=1 while KEY toggles 20 times -> zero pulses, move_count unchanged; lost falls with KEY[3] held -> no L until release and re-press.
REQ-031 With MOVE_REPEAT_EN, KEY[0] held 60 cycles (defaults) -> R pulses at t0, t0+16, t0+24, t0+32, ...; 256+ pulses -> move_count stays 255.
